// File: rtl/saturating_accumulator_scheduler.sv
// Shared saturating add/sub engine: N requesters, round-robin grant, one registered result slot.
module saturating_accumulator_scheduler #(
  parameter  int unsigned WORD_WIDTH = 8,
  parameter  int unsigned REQ_COUNT  = 4,
  localparam int unsigned ID_WIDTH   = $clog2(REQ_COUNT)
) (
  input  logic                            clock,
  input  logic                            clear,
  input  logic [WORD_WIDTH-1:0]           max_limit,
  input  logic [WORD_WIDTH-1:0]           min_limit,
  input  logic [REQ_COUNT-1:0]            req_valid,
  output logic [REQ_COUNT-1:0]            req_ready,
  input  logic [2*REQ_COUNT-1:0]          req_op,
  input  logic [WORD_WIDTH*REQ_COUNT-1:0] req_data,
  output logic                            result_valid,
  input  logic                            result_ready,
  output logic [WORD_WIDTH-1:0]           result_data,
  output logic [ID_WIDTH-1:0]             result_id,
  output logic                            result_carry,
  output logic                            result_clipped
);

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;
  localparam logic [1:0] OP_READ = 2'b11;

  logic [WORD_WIDTH-1:0] acc_q [REQ_COUNT];
  logic [WORD_WIDTH-1:0] acc_d [REQ_COUNT];
  logic [ID_WIDTH-1:0]   ptr_q, ptr_d;
  logic                  result_valid_q, result_valid_d;
  logic [WORD_WIDTH-1:0] result_data_q, result_data_d;
  logic [ID_WIDTH-1:0]   result_id_q, result_id_d;
  logic                  result_carry_q, result_carry_d;
  logic                  result_clipped_q, result_clipped_d;

  logic [1:0]            op_arr   [REQ_COUNT];
  logic [WORD_WIDTH-1:0] data_arr [REQ_COUNT];
  logic                  slot_free;
  logic                  grant_found;
  logic [ID_WIDTH-1:0]   grant_idx;
  int unsigned           rr_idx;

  logic [1:0]            op_sel;
  logic [WORD_WIDTH-1:0] a_word, b_word;
  logic signed [WORD_WIDTH:0] a_ext, b_ext, max_ext, min_ext, raw_ext, out_ext;
  logic                  new_carry, new_clipped;

  // Split the flat request buses into per-requester lanes
  always_comb begin
    for (int i = 0; i < REQ_COUNT; i++) begin
      op_arr[i]   = req_op[2*i +: 2];
      data_arr[i] = req_data[WORD_WIDTH*i +: WORD_WIDTH];
    end
  end

  assign slot_free = !result_valid_q || result_ready;

  // Round-robin grant: first valid requester at or above the pointer, with wrap
  always_comb begin
    req_ready   = '0;
    grant_found = 1'b0;
    grant_idx   = '0;
    rr_idx      = 0;
    if (!clear && slot_free) begin
      for (int unsigned k = 0; k < REQ_COUNT; k++) begin
        rr_idx = 32'(ptr_q) + k;
        if (rr_idx >= REQ_COUNT) rr_idx = rr_idx - REQ_COUNT;
        if (!grant_found && req_valid[ID_WIDTH'(rr_idx)]) begin
          grant_found = 1'b1;
          grant_idx   = ID_WIDTH'(rr_idx);
        end
      end
      if (grant_found) req_ready[grant_idx] = 1'b1;
    end
  end

  // Shared datapath on one extra bit so overflow is visible before clipping
  always_comb begin
    op_sel  = op_arr[grant_idx];
    a_word  = acc_q[grant_idx];
    b_word  = data_arr[grant_idx];
    a_ext   = {a_word[WORD_WIDTH-1], a_word};
    b_ext   = {b_word[WORD_WIDTH-1], b_word};
    max_ext = {max_limit[WORD_WIDTH-1], max_limit};
    min_ext = {min_limit[WORD_WIDTH-1], min_limit};
    raw_ext   = a_ext;
    new_carry = 1'b0;
    case (op_sel)
      OP_ADD: begin
        raw_ext   = a_ext + b_ext;
        new_carry = raw_ext[WORD_WIDTH];
      end
      OP_SUB: begin
        raw_ext   = a_ext - b_ext;
        new_carry = raw_ext[WORD_WIDTH];
      end
      OP_LOAD: raw_ext = b_ext;
      default: raw_ext = a_ext;
    endcase
    out_ext     = raw_ext;
    new_clipped = 1'b0;
    if (op_sel != OP_READ) begin
      if (raw_ext > max_ext) begin
        out_ext     = max_ext;
        new_clipped = 1'b1;
      end else if (raw_ext < min_ext) begin
        out_ext     = min_ext;
        new_clipped = 1'b1;
      end
    end
  end

  // Next state: accept updates acc and result slot, otherwise drain or hold
  always_comb begin
    acc_d            = acc_q;
    ptr_d            = ptr_q;
    result_valid_d   = result_valid_q;
    result_data_d    = result_data_q;
    result_id_d      = result_id_q;
    result_carry_d   = result_carry_q;
    result_clipped_d = result_clipped_q;
    if (grant_found) begin
      acc_d[grant_idx] = out_ext[WORD_WIDTH-1:0];
      result_valid_d   = 1'b1;
      result_data_d    = out_ext[WORD_WIDTH-1:0];
      result_id_d      = grant_idx;
      result_carry_d   = new_carry;
      result_clipped_d = new_clipped;
      ptr_d = (grant_idx == ID_WIDTH'(REQ_COUNT - 1)) ? '0 : grant_idx + ID_WIDTH'(1);
    end else if (result_ready) begin
      result_valid_d = 1'b0;
    end
  end

  // State registers with synchronous clear
  always_ff @(posedge clock) begin
    if (clear) begin
      for (int i = 0; i < REQ_COUNT; i++) acc_q[i] <= '0;
      ptr_q            <= '0;
      result_valid_q   <= 1'b0;
      result_data_q    <= '0;
      result_id_q      <= '0;
      result_carry_q   <= 1'b0;
      result_clipped_q <= 1'b0;
    end else begin
      acc_q            <= acc_d;
      ptr_q            <= ptr_d;
      result_valid_q   <= result_valid_d;
      result_data_q    <= result_data_d;
      result_id_q      <= result_id_d;
      result_carry_q   <= result_carry_d;
      result_clipped_q <= result_clipped_d;
    end
  end

  assign result_valid   = result_valid_q;
  assign result_data    = result_data_q;
  assign result_id      = result_id_q;
  assign result_carry   = result_carry_q;
  assign result_clipped = result_clipped_q;

endmodule

// File: tb/tb_saturating_accumulator_scheduler.sv
// Bench for saturating_accumulator_scheduler: directed scenarios plus random traffic vs an arithmetic model.
module tb_saturating_accumulator_scheduler;
  localparam int W = 8;
  localparam int N = 4;

  logic           clock = 1'b0;
  logic           clear;
  logic [W-1:0]   max_limit, min_limit;
  logic [N-1:0]   req_valid, req_ready;
  logic [2*N-1:0] req_op;
  logic [W*N-1:0] req_data;
  logic           result_valid, result_ready;
  logic [W-1:0]   result_data;
  logic [1:0]     result_id;
  logic           result_carry, result_clipped;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state
  int m_acc [N];
  int m_ptr;
  bit m_valid;
  int m_data;
  int m_id;
  bit m_carry, m_clip;

  saturating_accumulator_scheduler #(.WORD_WIDTH(W), .REQ_COUNT(N)) dut (
    .clock(clock), .clear(clear), .max_limit(max_limit), .min_limit(min_limit),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_data(req_data),
    .result_valid(result_valid), .result_ready(result_ready), .result_data(result_data),
    .result_id(result_id), .result_carry(result_carry), .result_clipped(result_clipped)
  );

  always #5 clock = ~clock;

  function automatic logic [N-1:0] model_grant();
    if (clear) return '0;
    if (m_valid && !result_ready) return '0;
    for (int k = 0; k < N; k++) begin
      int j = (m_ptr + k) % N;
      if (req_valid[2'(j)]) return N'(1) << j;
    end
    return '0;
  endfunction

  function automatic logic [12:0] model_result();
    return {m_valid, W'(m_data), 2'(m_id), m_carry, m_clip};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_acc[i] = 0;
    m_ptr = 0; m_valid = 0; m_data = 0; m_id = 0; m_carry = 0; m_clip = 0;
  endtask

  // Apply one rising edge worth of behaviour to the model
  task automatic model_edge();
    logic [N-1:0] g;
    int i, a, b, s, mx, mn;
    logic [1:0] op;
    g = model_grant();
    if (clear) begin
      model_reset();
    end else if (g != '0) begin
      i = 0;
      for (int k = 0; k < N; k++) if (g[2'(k)]) i = k;
      op = req_op[2*i +: 2];
      a  = m_acc[i];
      b  = $signed(req_data[W*i +: W]);
      mx = $signed(max_limit);
      mn = $signed(min_limit);
      m_carry = 0; m_clip = 0;
      case (op)
        2'd0: s = a + b;
        2'd1: s = a - b;
        2'd2: s = b;
        default: s = a;
      endcase
      if (op == 2'd0 || op == 2'd1) m_carry = s[8];
      if (op != 2'd3) begin
        if (s > mx) begin s = mx; m_clip = 1; end
        else if (s < mn) begin s = mn; m_clip = 1; end
      end
      m_acc[i] = s; m_data = s; m_id = i; m_valid = 1; m_ptr = (i + 1) % N;
    end else if (result_ready) begin
      m_valid = 0;
    end
  endtask

  task automatic advance();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic set_lane(input int i, input bit v, input logic [1:0] op, input logic [W-1:0] d);
    req_valid[2'(i)]  = v;
    req_op[2*i +: 2]  = op;
    req_data[W*i +: W] = d;
  endtask

  task automatic test_reset();
    clear = 1; req_valid = '1; req_op = '1; req_data = 32'h5A3C_7F81; result_ready = 1;
    max_limit = 8'sd127; min_limit = -8'sd128;
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      checks++;
      if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready cyc=%0d got=%b exp=0000", c, req_ready); end
      advance();
      checks++;
      if (result_valid !== 1'b0) begin failures++; $display("FAIL reset_valid cyc=%0d got=%b exp=0", c, result_valid); end
    end
    clear = 0;
    for (int c = 0; c < N; c++) begin
      @(negedge clock);
      checks++;
      if (req_ready !== N'(1) << c) begin failures++; $display("FAIL reset_read_grant cyc=%0d got=%b exp=%b", c, req_ready, N'(1) << c); end
      advance();
      checks++;
      if (result_data !== 8'h00 || result_id !== 2'(c) || result_valid !== 1'b1) begin
        failures++; $display("FAIL reset_read cyc=%0d got data=%h id=%0d v=%b exp data=00 id=%0d v=1", c, result_data, result_id, result_valid, c);
      end
    end
  endtask

  task automatic test_round_robin();
    max_limit = 8'sd127; min_limit = -8'sd128; result_ready = 1;
    for (int i = 0; i < N; i++) set_lane(i, 1, 2'b00, 8'd1);
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      checks++;
      if (req_ready !== N'(1) << (c % N)) begin failures++; $display("FAIL rr_grant cyc=%0d got=%b exp=%b", c, req_ready, N'(1) << (c % N)); end
      advance();
      checks++;
      if (result_data !== W'(c / N + 1) || result_id !== 2'(c % N)) begin
        failures++; $display("FAIL rr_result cyc=%0d got data=%0d id=%0d exp data=%0d id=%0d", c, result_data, result_id, c / N + 1, c % N);
      end
      checks++;
      if ({result_valid, result_data, result_id, result_carry, result_clipped} !== model_result()) begin
        failures++; $display("FAIL rr_model cyc=%0d got=%h exp=%h", c, {result_valid, result_data, result_id, result_carry, result_clipped}, model_result());
      end
    end
  endtask

  task automatic test_saturation();
    logic [1:0] ops [3] = '{2'b10, 2'b00, 2'b01};
    logic [7:0] dat [3] = '{8'd120, 8'd10, 8'hC8};
    logic [7:0] exd [3] = '{8'd120, 8'd127, 8'd127};
    bit         exc [3] = '{0, 1, 1};
    max_limit = 8'sd127; min_limit = -8'sd128; result_ready = 1; req_valid = '0;
    for (int s = 0; s < 3; s++) begin
      set_lane(0, 1, ops[s], dat[s]);
      @(negedge clock);
      checks++;
      if (req_ready !== 4'b0001) begin failures++; $display("FAIL sat_grant step=%0d got=%b exp=0001", s, req_ready); end
      advance();
      checks++;
      if (result_data !== exd[s] || result_clipped !== exc[s] || result_carry !== 1'b0) begin
        failures++; $display("FAIL sat_result step=%0d got data=%0d clip=%b carry=%b exp data=%0d clip=%b carry=0", s, result_data, result_clipped, result_carry, exd[s], exc[s]);
      end
    end
    req_valid = '0;
  endtask

  task automatic test_narrow_limits();
    logic [1:0] ops [4] = '{2'b10, 2'b01, 2'b00, 2'b10};
    logic [7:0] dat [4] = '{8'd0, 8'd8, 8'd3, 8'd50};
    logic [7:0] exd [4] = '{8'h00, 8'hFB, 8'hFE, 8'h0A};
    bit         exc [4] = '{0, 1, 0, 1};
    bit         exy [4] = '{0, 1, 1, 0};
    max_limit = 8'sd10; min_limit = -8'sd5; result_ready = 1; req_valid = '0;
    for (int s = 0; s < 4; s++) begin
      set_lane(1, 1, ops[s], dat[s]);
      @(negedge clock);
      checks++;
      if (req_ready !== 4'b0010) begin failures++; $display("FAIL narrow_grant step=%0d got=%b exp=0010", s, req_ready); end
      advance();
      checks++;
      if (result_data !== exd[s] || result_clipped !== exc[s] || result_carry !== exy[s] || result_id !== 2'd1) begin
        failures++; $display("FAIL narrow_result step=%0d got data=%h clip=%b carry=%b id=%0d exp data=%h clip=%b carry=%b id=1", s, result_data, result_clipped, result_carry, result_id, exd[s], exc[s], exy[s]);
      end
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    logic [12:0] snap;
    int saved_ptr;
    max_limit = 8'sd127; min_limit = -8'sd128; result_ready = 1;
    for (int i = 0; i < N; i++) set_lane(i, 1, 2'b00, W'(i + 1));
    advance();
    result_ready = 0;
    snap = model_result();
    saved_ptr = m_ptr;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      checks++;
      if (req_ready !== 4'b0000) begin failures++; $display("FAIL stall_ready cyc=%0d got=%b exp=0000", c, req_ready); end
      advance();
      checks++;
      if ({result_valid, result_data, result_id, result_carry, result_clipped} !== snap) begin
        failures++; $display("FAIL stall_stable cyc=%0d got=%h exp=%h", c, {result_valid, result_data, result_id, result_carry, result_clipped}, snap);
      end
    end
    result_ready = 1;
    @(negedge clock);
    checks++;
    if (req_ready !== N'(1) << saved_ptr) begin failures++; $display("FAIL release_grant got=%b exp=%b", req_ready, N'(1) << saved_ptr); end
    advance();
    checks++;
    if ({result_valid, result_data, result_id, result_carry, result_clipped} !== model_result() || result_id !== 2'(saved_ptr)) begin
      failures++; $display("FAIL release_result got=%h exp=%h", {result_valid, result_data, result_id, result_carry, result_clipped}, model_result());
    end
  endtask

  task automatic test_reset_mid();
    result_ready = 0; clear = 1;
    @(negedge clock);
    checks++;
    if (req_ready !== 4'b0000) begin failures++; $display("FAIL midclr_ready got=%b exp=0000", req_ready); end
    advance();
    checks++;
    if (result_valid !== 1'b0) begin failures++; $display("FAIL midclr_valid got=%b exp=0", result_valid); end
    clear = 0; result_ready = 1;
    for (int i = 0; i < N; i++) set_lane(i, 1, 2'b11, 8'hA5);
    for (int c = 0; c < N; c++) begin
      @(negedge clock);
      checks++;
      if (req_ready !== N'(1) << c) begin failures++; $display("FAIL midclr_grant cyc=%0d got=%b exp=%b", c, req_ready, N'(1) << c); end
      advance();
      checks++;
      if (result_data !== 8'h00 || result_clipped !== 1'b0 || result_carry !== 1'b0) begin
        failures++; $display("FAIL midclr_read cyc=%0d got data=%h clip=%b carry=%b exp 00/0/0", c, result_data, result_clipped, result_carry);
      end
    end
  endtask

  task automatic test_random();
    logic [N-1:0] pend_v, g;
    logic [1:0]   pend_op [N];
    logic [W-1:0] pend_d  [N];
    logic [W-1:0] la, lb;
    pend_v = '0;
    for (int c = 0; c < 400; c++) begin
      if (c % 25 == 0) begin
        la = W'($urandom); lb = W'($urandom);
        if ($signed(la) >= $signed(lb)) begin max_limit = la; min_limit = lb; end
        else begin max_limit = lb; min_limit = la; end
      end
      for (int i = 0; i < N; i++) begin
        if (!pend_v[2'(i)] && $urandom_range(0, 1) == 1) begin
          pend_v[2'(i)] = 1'b1;
          pend_op[i] = 2'($urandom);
          pend_d[i]  = W'($urandom);
        end
        set_lane(i, pend_v[2'(i)], pend_op[i], pend_d[i]);
      end
      result_ready = ($urandom_range(0, 3) != 0);
      clear = ($urandom_range(0, 99) == 0);
      @(negedge clock);
      g = model_grant();
      checks++;
      if (req_ready !== g) begin failures++; $display("FAIL rand_grant cyc=%0d got=%b exp=%b", c, req_ready, g); end
      advance();
      checks++;
      if ({result_valid, result_data, result_id, result_carry, result_clipped} !== model_result()) begin
        failures++; $display("FAIL rand_result cyc=%0d got=%h exp=%h", c, {result_valid, result_data, result_id, result_carry, result_clipped}, model_result());
      end
      pend_v = pend_v & ~g;
    end
    clear = 0;
  endtask

  initial begin
    model_reset();
    clear = 1; req_valid = '0; req_op = '0; req_data = '0; result_ready = 1;
    max_limit = 8'sd127; min_limit = -8'sd128;
    @(posedge clock);
    #1;
    test_reset();
    test_round_robin();
    test_saturation();
    test_narrow_limits();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
